// File: rtl/fifo_sync_prog.sv
// rtl/fifo_sync_prog.sv - single-clock FIFO with programmable thresholds and FWFT option
module fifo_sync_prog #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4,
  parameter int FWFT  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               winc,
  input  logic [DSIZE-1:0]   wdata,
  input  logic               rinc,
  output logic [DSIZE-1:0]   rdata,
  input  logic [ASIZE:0]     afull_thr,
  input  logic [ASIZE:0]     aempty_thr,
  input  logic               err_clr,
  output logic [ASIZE:0]     count,
  output logic               wfull,
  output logic               afull,
  output logic               rempty,
  output logic               aempty,
  output logic               overflow,
  output logic               underflow
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_W = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] ONE_W   = (ASIZE+1)'(1);

  logic [DSIZE-1:0] mem_q [DEPTH];
  logic [ASIZE:0]   wptr_q, wptr_d;
  logic [ASIZE:0]   rptr_q, rptr_d;
  logic [ASIZE:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc, rd_acc;
  logic             ptr_msb_unused;

  // Flags come from the registered count, so accept decisions never see same-cycle traffic.
  assign wfull  = (count_q == DEPTH_W);
  assign rempty = (count_q == '0);
  assign afull  = (count_q >= afull_thr);
  assign aempty = (count_q <= aempty_thr);
  assign count  = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  assign wr_acc = winc & ~wfull;
  assign rd_acc = rinc & ~rempty;

  // Occupancy lives in count_q; the pointer MSBs only keep the wrap arithmetic conventional.
  assign ptr_msb_unused = wptr_q[ASIZE] ^ rptr_q[ASIZE];

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = (overflow_q & ~err_clr) | (winc & wfull);
    underflow_d = (underflow_q & ~err_clr) | (rinc & rempty);
    if (wr_acc) wptr_d = wptr_q + ONE_W;
    if (rd_acc) rptr_d = rptr_q + ONE_W;
    if (wr_acc && !rd_acc) count_d = count_q + ONE_W;
    else if (rd_acc && !wr_acc) count_d = count_q - ONE_W;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q[ASIZE-1:0]] <= wdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = mem_q[rptr_q[ASIZE-1:0]];
    end else begin : g_reg
      logic [DSIZE-1:0] rdata_q, rdata_d;

      always_comb begin
        rdata_d = rdata_q;
        if (rd_acc) rdata_d = mem_q[rptr_q[ASIZE-1:0]];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
      end

      assign rdata = rdata_q;
    end
  endgenerate

endmodule
